johnson_phase_decoder: RTL and testbench
========================================

Name: johnson_phase_decoder

Overview:
- Downstream consumer of the 4-stage Johnson counter.
- Samples the counter's q bus and decodes each of the 2*WIDTH legal Johnson codes into a registered one-hot phase and a binary phase index.
- Supervises the sequence with a lock/fault state machine, counts full revolutions, and flags illegal codes or illegal steps (stuck or corrupted flops).

Parameters:
- WIDTH, 4, number of Johnson stages; the sequence has 2*WIDTH states.
- LOCK_CNT, 2, consecutive legal transitions (advance or hold) required to enter LOCKED; range 1..15.
- REV_W, 8, width of the revolution counter.

Ports:
- clk  input  1  rising-edge clock, shared with the Johnson counter.
- clr  input  1  asynchronous active-low reset.
- q  input  WIDTH  Johnson counter state, synchronous to clk.
- qb  input  WIDTH  complement rail; present only when JPD_DUAL_RAIL_CHECK_EN is defined.
- err_clr  input  1  single-cycle pulse that leaves FAULT.
- phase_oh  output  2*WIDTH  one-hot phase, all zero unless LOCKED.
- phase_idx  output  clog2(2*WIDTH)  binary phase, 0 unless LOCKED.
- locked  output  1  high in LOCKED.
- err  output  1  sticky fault flag.
- rev_tick  output  1  one-cycle pulse on each phase 2*WIDTH-1 -> 0 advance while LOCKED.
- rev_cnt  output  REV_W  revolution count; wraps modulo 2^REV_W.

Behaviour:
- Reset:
  - clr low asynchronously forces state ACQ, acq count 0, input registers 0.
  - All outputs go to 0: phase_oh, phase_idx, locked, err, rev_tick, rev_cnt.
- Pipeline:
  - q_r <= q on each edge; q_p <= q_r.
  - All checks compare q_r (current) against q_p (previous).
  - Outputs are registered: a change on q appears on phase_oh 2 clocks later.
- Code legality: q_r is legal iff it is 0...01...1 or 1...10...0 (contiguous ones anchored at one end). For WIDTH=4: 0000, 0001, 0011, 0111, 1111, 1110, 1100, 1000.
- Index rule (p = popcount):
  - If q_r[WIDTH-1] = 0, index = p.
  - Otherwise index = 2*WIDTH - p.
  - Examples: 0000->0, 0111->3, 1111->4, 1000->7.
- Successor: succ(x) = {x[WIDTH-2:0], ~x[WIDTH-1]}.
- Step classification:
  - Legal step: q_r == q_p (hold), or q_r == succ(q_p) (advance).
  - Any other change is a bad step.
  - A step is evaluated only when both q_r and q_p are legal codes.
- FSM ACQ:
  - Legal code plus legal step increments the acq count.
  - When the count reaches LOCK_CNT, go to LOCKED; the outputs reflect the current phase on the same edge.
  - An illegal code or bad step clears the count and stays in ACQ. err is not set.
- FSM LOCKED:
  - phase_oh[idx] = 1; locked = 1.
  - An illegal code or bad step goes to FAULT, sets err, zeroes phase_oh, phase_idx and locked.
- FSM FAULT:
  - err holds.
  - err_clr = 1 with no new fault condition that cycle: clear err, go to ACQ with count 0.
  - Fault condition and err_clr in the same cycle: fault wins, stay in FAULT.
  - err_clr in ACQ or LOCKED is ignored.
- Revolutions:
  - In LOCKED, an advance from index 2*WIDTH-1 to 0 pulses rev_tick for one cycle and increments rev_cnt.
  - rev_cnt wraps from all-ones to 0.
  - A hold does not tick.
  - rev_cnt is kept across FAULT and ACQ; only clr clears it.
- Upstream reset: the counter's power-up state 0000 is legal. A repeated 0000 is a hold, so the decoder locks even if the counter is stalled.

Optional Feature:
- Macro: JPD_DUAL_RAIL_CHECK_EN.
- Defined:
  - The qb port exists and is registered alongside q.
  - Any cycle with qb_r != ~q_r counts as a fault condition: in LOCKED it goes to FAULT; in ACQ it clears the count.
- Undefined: no qb port, no rail check; behaviour is otherwise identical.

Decomposition:
- Package johnson_pkg:
  - State typedef jpd_state_t {ACQ, LOCKED, FAULT}.
  - Functions jc_legal(x), jc_succ(x), jc_index(x), parameterised by WIDTH.
- One combinational sub-module, johnson_code_check:
  - Inputs: cur, prev.
  - Outputs: legal, advance, hold, index.
  - It instantiates the package functions and keeps the FSM file purely sequential.

Test Plan:
- Reset and lock:
  - Stimulus: clr low, then release; drive the legal sequence 0000, 0001, 0011, ... one step per clock.
  - Response: locked rises after LOCK_CNT=2 legal steps. phase_oh tracks 2 clocks behind q: 0001 -> 8'b0000_0010, idx 1.
- Revolutions: 3 full cycles of 8 states while LOCKED -> 3 rev_tick pulses, rev_cnt = 3. With REV_W=2, a 4th revolution wraps rev_cnt to 0.
- Illegal code: inject 0101 while LOCKED -> err = 1, locked = 0, phase_oh = 0, state FAULT; err stays high through later legal codes.
- Bad step: jump 0011 -> 1110 while LOCKED -> FAULT. err_clr together with a new bad step -> still FAULT. A lone err_clr pulse -> err = 0, ACQ, relock after 2 legal steps.
- Stall and async reset: q held at 0111 for 10 cycles -> stays LOCKED, idx 3, no rev_tick. clr pulsed low mid-sequence -> all outputs 0 immediately, rev_cnt = 0.
- Dual rail, with JPD_DUAL_RAIL_CHECK_EN: q = 0011 with qb = 1101 while LOCKED -> FAULT, err = 1. Same stimulus with the macro undefined -> no qb port, remains LOCKED.

Source files
------------

// File: rtl/johnson_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | johnson_pkg: state type and Johnson-code helper functions         |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
package johnson_pkg;

  localparam int JC_MAX_W     = 16;
  localparam int JC_IDX_MAX_W = 6;

  typedef logic [JC_MAX_W-1:0] jc_word_t;

  typedef enum logic [1:0] {
    ACQ    = 2'd0,
    LOCKED = 2'd1,
    FAULT  = 2'd2
  } jpd_state_t;

  // A legal code has at most one 0/1 boundary between adjacent bits.
  function automatic logic jc_legal(input jc_word_t x, input int w);
    int edges;
    edges = 0;
    for (int i = 0; i < JC_MAX_W - 1; i++) begin
      if ((i < w - 1) && (x[i] != x[i+1])) edges++;
    end
    return (edges <= 1);
  endfunction

  function automatic jc_word_t jc_succ(input jc_word_t x, input int w);
    jc_word_t r;
    r = '0;
    for (int i = 1; i < JC_MAX_W; i++) begin
      if (i < w) r[i] = x[i-1];
    end
    for (int i = 0; i < JC_MAX_W; i++) begin
      if (i == w - 1) r[0] = ~x[i];
    end
    return r;
  endfunction

  function automatic logic [JC_IDX_MAX_W-1:0] jc_index(input jc_word_t x, input int w);
    int   p;
    logic msb;
    p   = 0;
    msb = 1'b0;
    for (int i = 0; i < JC_MAX_W; i++) begin
      if (i < w) p += int'(x[i]);
      if (i == w - 1) msb = x[i];
    end
    return msb ? JC_IDX_MAX_W'(2 * w - p) : JC_IDX_MAX_W'(p);
  endfunction

endpackage
`default_nettype wire

// File: rtl/johnson_code_check.sv
`default_nettype none
// +------------------------------------------------------------------+
// | johnson_code_check: combinational legality/step/index decode      |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module johnson_code_check
  import johnson_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int IDX_W = 3
) (
  input  logic [WIDTH-1:0] cur,
  input  logic [WIDTH-1:0] prev,
  output logic             legal,
  output logic             advance,
  output logic             hold,
  output logic             bad_step,
  output logic [IDX_W-1:0] index
);

  jc_word_t w_cur;
  jc_word_t w_prev;
  logic     w_prev_legal;
  logic     w_both_legal;

  always_comb begin
    w_cur        = JC_MAX_W'(cur);
    w_prev       = JC_MAX_W'(prev);
    legal        = jc_legal(w_cur, WIDTH);
    w_prev_legal = jc_legal(w_prev, WIDTH);
    // Steps are only judged between two legal codes.
    w_both_legal = legal && w_prev_legal;
    hold         = w_both_legal && (w_cur == w_prev);
    advance      = w_both_legal && (w_cur == jc_succ(w_prev, WIDTH));
    bad_step     = w_both_legal && !hold && !advance;
    index        = IDX_W'(jc_index(w_cur, WIDTH));
  end

endmodule
`default_nettype wire

// File: rtl/johnson_phase_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | johnson_phase_decoder: Johnson phase decode, lock/fault FSM and   |
// | revolution counter. JPD_DUAL_RAIL_CHECK_EN adds the qb rail check.|
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module johnson_phase_decoder
  import johnson_pkg::*;
#(
  parameter int WIDTH    = 4,
  parameter int LOCK_CNT = 2,
  parameter int REV_W    = 8
) (
  input  logic                           clk,
  input  logic                           clr,
  input  logic [WIDTH-1:0]               q,
`ifdef JPD_DUAL_RAIL_CHECK_EN
  input  logic [WIDTH-1:0]               qb,
`endif
  input  logic                           err_clr,
  output logic [2*WIDTH-1:0]             phase_oh,
  output logic [$clog2(2*WIDTH)-1:0]     phase_idx,
  output logic                           locked,
  output logic                           err,
  output logic                           rev_tick,
  output logic [REV_W-1:0]               rev_cnt
);

  localparam int         c_phases   = 2 * WIDTH;
  localparam int         c_idx_w    = $clog2(c_phases);
  localparam logic [3:0] c_lock_cnt = 4'(LOCK_CNT);

  jpd_state_t            r_state, w_state_nx;
  logic [3:0]            r_acq, w_acq_nx, w_acq_inc;
  logic [WIDTH-1:0]      r_q, r_q_p;
  logic [c_phases-1:0]   r_phase_oh, w_phase_oh_nx, w_onehot;
  logic [c_idx_w-1:0]    r_phase_idx, w_phase_idx_nx, w_index;
  logic                  r_locked, w_locked_nx;
  logic                  r_err, w_err_nx;
  logic                  r_rev_tick, w_rev_tick_nx;
  logic [REV_W-1:0]      r_rev_cnt, w_rev_cnt_nx;
  logic                  w_legal, w_advance, w_hold, w_bad_step;
  logic                  w_rail_bad, w_fault, w_good;

  johnson_code_check #(
    .WIDTH (WIDTH),
    .IDX_W (c_idx_w)
  ) u_check (
    .cur      (r_q),
    .prev     (r_q_p),
    .legal    (w_legal),
    .advance  (w_advance),
    .hold     (w_hold),
    .bad_step (w_bad_step),
    .index    (w_index)
  );

`ifdef JPD_DUAL_RAIL_CHECK_EN
  logic [WIDTH-1:0] r_qb;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) r_qb <= '0;
    else      r_qb <= qb;
  end

  assign w_rail_bad = (r_qb != ~r_q);
`else
  assign w_rail_bad = 1'b0;
`endif

  assign w_fault   = !w_legal || w_bad_step || w_rail_bad;
  assign w_good    = w_legal && (w_advance || w_hold) && !w_rail_bad;
  assign w_acq_inc = r_acq + 4'd1;
  assign w_onehot  = {{(c_phases-1){1'b0}}, 1'b1} << w_index;

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      r_q         <= '0;
      r_q_p       <= '0;
      r_state     <= ACQ;
      r_acq       <= '0;
      r_phase_oh  <= '0;
      r_phase_idx <= '0;
      r_locked    <= 1'b0;
      r_err       <= 1'b0;
      r_rev_tick  <= 1'b0;
      r_rev_cnt   <= '0;
    end else begin
      r_q         <= q;
      r_q_p       <= r_q;
      r_state     <= w_state_nx;
      r_acq       <= w_acq_nx;
      r_phase_oh  <= w_phase_oh_nx;
      r_phase_idx <= w_phase_idx_nx;
      r_locked    <= w_locked_nx;
      r_err       <= w_err_nx;
      r_rev_tick  <= w_rev_tick_nx;
      r_rev_cnt   <= w_rev_cnt_nx;
    end
  end

  always_comb begin
    w_state_nx     = r_state;
    w_acq_nx       = r_acq;
    w_phase_oh_nx  = '0;
    w_phase_idx_nx = '0;
    w_locked_nx    = 1'b0;
    w_err_nx       = r_err;
    w_rev_tick_nx  = 1'b0;
    w_rev_cnt_nx   = r_rev_cnt;
    case (r_state)
      ACQ: begin
        if (w_good) begin
          if (w_acq_inc == c_lock_cnt) begin
            w_state_nx     = LOCKED;
            w_acq_nx       = '0;
            w_locked_nx    = 1'b1;
            w_phase_oh_nx  = w_onehot;
            w_phase_idx_nx = w_index;
          end else begin
            w_acq_nx = w_acq_inc;
          end
        end else begin
          w_acq_nx = '0;
        end
      end
      LOCKED: begin
        if (w_fault) begin
          w_state_nx = FAULT;
          w_err_nx   = 1'b1;
        end else begin
          w_locked_nx    = 1'b1;
          w_phase_oh_nx  = w_onehot;
          w_phase_idx_nx = w_index;
          // Only an advance can land on index 0 from the last phase.
          if (w_advance && (w_index == '0)) begin
            w_rev_tick_nx = 1'b1;
            w_rev_cnt_nx  = r_rev_cnt + 1'b1;
          end
        end
      end
      FAULT: begin
        if (err_clr && !w_fault) begin
          w_state_nx = ACQ;
          w_acq_nx   = '0;
          w_err_nx   = 1'b0;
        end
      end
      default: begin
        w_state_nx = ACQ;
        w_acq_nx   = '0;
      end
    endcase
  end

  assign phase_oh  = r_phase_oh;
  assign phase_idx = r_phase_idx;
  assign locked    = r_locked;
  assign err       = r_err;
  assign rev_tick  = r_rev_tick;
  assign rev_cnt   = r_rev_cnt;

endmodule
`default_nettype wire

// File: tb/tb_johnson_phase_decoder.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_johnson_phase_decoder: random + directed bench with a          |
// | phase-table reference model. Rev 1.0                              |
// +------------------------------------------------------------------+
module tb_johnson_phase_decoder;

  localparam int W     = 4;
  localparam int PH    = 2 * W;
  localparam int LOCKN = 2;
  localparam int REVW  = 2;
`ifdef JPD_DUAL_RAIL_CHECK_EN
  localparam bit DUAL  = 1'b1;
`else
  localparam bit DUAL  = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             clr;
  logic [W-1:0]     q;
  logic [W-1:0]     qb;
  logic             err_clr;
  logic [PH-1:0]    phase_oh;
  logic [2:0]       phase_idx;
  logic             locked;
  logic             err;
  logic             rev_tick;
  logic [REVW-1:0]  rev_cnt;

  johnson_phase_decoder #(
    .WIDTH    (W),
    .LOCK_CNT (LOCKN),
    .REV_W    (REVW)
  ) dut (
    .clk       (clk),
    .clr       (clr),
    .q         (q),
`ifdef JPD_DUAL_RAIL_CHECK_EN
    .qb        (qb),
`endif
    .err_clr   (err_clr),
    .phase_oh  (phase_oh),
    .phase_idx (phase_idx),
    .locked    (locked),
    .err       (err),
    .rev_tick  (rev_tick),
    .rev_cnt   (rev_cnt)
  );

  always #5 clk = ~clk;

  int n_checks;
  int n_errors;
  int pos;

  // Reference model: phases are positions in the ordered code table.
  int           m_mode;   // 0 acquiring, 1 locked, 2 faulted
  int           m_run;
  logic [W-1:0] m_qr, m_qp;
  bit           m_rail;
  logic [PH-1:0] e_oh;
  int           e_idx, e_rev;
  bit           e_locked, e_err, e_tick;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] code_at(input int k);
    int v;
    if (k <= W) v = (1 << k) - 1;
    else        v = (((1 << W) - 1) << (k - W)) & ((1 << W) - 1);
    return W'(v);
  endfunction

  function automatic int code_pos(input logic [W-1:0] x);
    for (int k = 0; k < PH; k++) if (x == code_at(k)) return k;
    return -1;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_run = 0; m_qr = '0; m_qp = '0; m_rail = !DUAL;
    e_oh = '0; e_idx = 0; e_rev = 0; e_locked = 0; e_err = 0; e_tick = 0;
  endtask

  task automatic model_edge(input logic [W-1:0] v, input bit c, input bit rail_ok);
    int pc, pp;
    bit step_ok, fault;
    pc      = code_pos(m_qr);
    pp      = code_pos(m_qp);
    step_ok = (pc >= 0) && (pp >= 0) && ((pc == pp) || (pc == (pp + 1) % PH));
    fault   = (pc < 0) || ((pp >= 0) && !step_ok) || (DUAL && !m_rail);
    e_tick  = 0;
    if (m_mode == 0) begin
      if (step_ok && !(DUAL && !m_rail)) begin
        m_run++;
        if (m_run == LOCKN) begin m_mode = 1; m_run = 0; end
      end else m_run = 0;
    end else if (m_mode == 1) begin
      if (fault) m_mode = 2;
      else if (pp == PH - 1 && pc == 0) begin
        e_tick = 1;
        e_rev  = (e_rev + 1) % (1 << REVW);
      end
    end else if (c && !fault) begin
      m_mode = 0; m_run = 0;
    end
    e_locked = (m_mode == 1);
    e_err    = (m_mode == 2);
    e_idx    = e_locked ? pc : 0;
    e_oh     = e_locked ? (PH'(1) << pc) : '0;
    m_qp = m_qr; m_qr = v; m_rail = rail_ok;
  endtask

  task automatic check_all(input string pfx);
    check({pfx, "phase_oh"},  32'(phase_oh),  32'(e_oh));
    check({pfx, "phase_idx"}, 32'(phase_idx), 32'(e_idx));
    check({pfx, "locked"},    32'(locked),    32'(e_locked));
    check({pfx, "err"},       32'(err),       32'(e_err));
    check({pfx, "rev_tick"},  32'(rev_tick),  32'(e_tick));
    check({pfx, "rev_cnt"},   32'(rev_cnt),   32'(e_rev));
  endtask

  // Called at a negedge; returns at the following negedge.
  task automatic step(input logic [W-1:0] v, input bit c, input bit rail_ok);
    q       = v;
    err_clr = c;
    qb      = rail_ok ? ~v : (~v ^ {{(W-1){1'b0}}, 1'b1});
    @(posedge clk);
    model_edge(v, c, rail_ok);
    #1;
    check_all("");
    @(negedge clk);
  endtask

  task automatic adv();
    pos = (pos + 1) % PH;
    step(code_at(pos), 1'b0, 1'b1);
  endtask

  task automatic rand_step();
    int r, p;
    logic [W-1:0] v;
    r = $urandom_range(0, 99);
    if (r < 60) begin
      pos = (pos + 1) % PH; v = code_at(pos);
    end else if (r < 80) begin
      v = code_at(pos);
    end else if (r < 88) begin
      v = W'($urandom_range(0, (1 << W) - 1));
      p = code_pos(v);
      if (p >= 0) pos = p;
    end else begin
      pos = $urandom_range(0, PH - 1); v = code_at(pos);
    end
    step(v, ($urandom_range(0, 9) == 0), ($urandom_range(0, 29) != 0));
  endtask

  initial begin
    n_checks = 0; n_errors = 0; pos = 0;
    clr = 1'b0; q = '0; qb = '1; err_clr = 1'b0;
    model_reset();
    #12;
    check_all("reset_");
    @(negedge clk);
    clr = 1'b1;

    // Lock from the power-up code, then 4+ revolutions (REV_W=2 wraps).
    for (int k = 0; k < 36; k++) begin
      pos = k % PH;
      step(code_at(pos), 1'b0, 1'b1);
    end

    // Stall at 0111.
    repeat (10) step(code_at(pos), 1'b0, 1'b1);

    // Rail mismatch: faults only in the dual-rail build.
    step(code_at(pos), 1'b0, 1'b0);
    repeat (2) step(code_at(pos), 1'b0, 1'b1);
    step(code_at(pos), 1'b1, 1'b1);
    repeat (4) adv();

    // Illegal code while locked; err must survive legal codes.
    step(4'b0101, 1'b0, 1'b1);
    repeat (3) adv();
    repeat (2) step(code_at(pos), 1'b0, 1'b1);
    step(code_at(pos), 1'b1, 1'b1);
    repeat (4) adv();

    // Bad step 0011 -> 1110, then err_clr racing a second bad step.
    for (int g = 0; g < PH && pos != 2; g++) adv();
    step(code_at(5), 1'b0, 1'b1);
    pos = 5;
    repeat (2) step(code_at(pos), 1'b0, 1'b1);
    pos = 1;
    step(code_at(pos), 1'b0, 1'b1);
    step(code_at(pos), 1'b1, 1'b1);
    step(code_at(pos), 1'b0, 1'b1);
    step(code_at(pos), 1'b1, 1'b1);
    repeat (4) adv();

    repeat (400) rand_step();

    // Asynchronous reset mid-sequence.
    #2 clr = 1'b0;
    #1;
    model_reset();
    check_all("async_rst_");
    @(negedge clk);
    clr = 1'b1;
    pos = 0;
    repeat (150) rand_step();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
